row_serializer: RTL
===================

# row_serializer

Parametrised row-to-stream serialiser for the RAM read path. Accepts one full RAM row per valid/ready handshake and emits it as a stream of LANES-bit beats, each tagged with its bit index and a last flag. Supports a per-row emit length and downstream back-pressure. Sits between the row-RAM read port and the per-bit processing pipeline.

## Interface
- ROW_W, 1280: row width in bits; ≥ LANES.
- LANES, 1: bits per output beat; ROW_W % LANES == 0 (elaboration error otherwise).
- IDX_W, $clog2(ROW_W): derived; bit index width.
- LEN_W, $clog2(ROW_W+1): derived; length width.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  row available.
- in_ready  out  1  block can accept a row.
- in_data  in  ROW_W  row data; bit 0 emitted first.
- in_len  in  LEN_W  number of bits to emit from this row; values > ROW_W clamp to ROW_W.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts beat.
- out_bits  out  LANES  row[out_index +: LANES]; lanes at or beyond len forced to 0.
- out_index  out  IDX_W  bit index of out_bits[0].
- out_last  out  1  final beat of the row.
- busy  out  1  a row is being emitted (state EMIT).

## Operation
- States: IDLE, EMIT.
- IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, latch in_data and clamped in_len, set index=0. If len==0, the row is consumed and the state stays IDLE with no beats emitted; otherwise go to EMIT.
- EMIT: out_valid=1. out_last = (index+LANES >= len); the sum is computed in LEN_W+1 bits, with no wrap. On out_valid&&out_ready: if !out_last, index += LANES; if out_last, go to IDLE (or reload, see Configuration).
- Partial final beat (len not a multiple of LANES): lanes with index+k >= len are driven 0.
- Back-pressure: while out_valid && !out_ready, out_bits, out_index and out_last hold stable.
- Index never exceeds ROW_W-LANES; no wrap-around.
- Row input is ignored when in_ready=0.

## Timing
- All outputs are registered. Reset values: in_ready=1 (IDLE), out_valid=0, out_bits=0, out_index=0, out_last=0, busy=0.
- Input handshake at edge t → first beat (index 0) valid after edge t+1.
- One beat per cycle with out_ready held high: a row of len bits takes ceil(len/LANES) cycles.
- Base build: after the last beat handshake there is one IDLE cycle before the next row can be accepted, which gives a 1-cycle bubble.
- Reset mid-row: the row is discarded immediately and all outputs return to reset values; no partial completion occurs after reset.

## Configuration
- ROW_SERIALIZER_PRELOAD_EN defined:
  - Adds a one-row shadow buffer. in_ready = !shadow_full, in both IDLE and EMIT.
  - A row accepted during EMIT goes to the shadow buffer.
  - On the last-beat handshake with shadow_full, the shadow row moves into the active row, index resets to 0, the block stays in EMIT, and out_valid stays 1. Back-to-back rows therefore have zero bubble.
  - A shadow row with len==0 is dropped at transfer.
  - A simultaneous shadow transfer and new input handshake is legal; the new row goes into the freed shadow slot.
- ROW_SERIALIZER_PRELOAD_EN not defined: single buffer, with behaviour exactly as in Operation/Timing.

## Structure
- row_serializer_pkg: state enum (IDLE, EMIT), width helper functions, and an elaboration-check macro for ROW_W % LANES.
- Sub-module row_shadow_buf: holds one row and its length, with full flag, load and take; instantiated only under ROW_SERIALIZER_PRELOAD_EN.

## Test plan
- ROW_W=16, LANES=1, in_len=16, data 0xA5C3, out_ready=1 → 16 beats with out_bits = bits 0..15 of 0xA5C3, out_index 0..15, out_last only at index 15, then in_ready=1.
- ROW_W=16, LANES=4, in_len=10, data 0xFFFF → beats 0xF@0, 0xF@4, 0x3@8 (last), i.e. lanes 10,11 zeroed.
- out_ready toggled 1,0,0,1 every beat → no beat lost or duplicated, and outputs are stable during stalls.
- in_len=0 → no out_valid, and in_ready returns to 1 on the next cycle; in_len=20 with ROW_W=16 → clamped, 16 bits emitted.
- reset asserted at beat 5 of 16 → out_valid=0 at once; a new row after release starts at index 0.
- PRELOAD_EN: two rows offered back-to-back, out_ready=1 → index sequence 0..15, 0..15 with no gap cycle; the second in_ready handshake occurs during the first row.

Source files
------------

// File: rtl/row_serializer_pkg.sv
// Shared types and helpers for the row serializer.
// Contents:
//   state_t                   - FSM state encoding (IDLE, EMIT)
//   idx_width / len_width     - derived widths for bit index and emit length
//   ROW_SERIALIZER_ASSERT_DIV - elaboration check that ROW_W is a multiple of LANES
`ifndef ROW_SERIALIZER_PKG_SV
`define ROW_SERIALIZER_PKG_SV

// Expands to a generate-if that stops elaboration on an illegal lane split.
`define ROW_SERIALIZER_ASSERT_DIV(row_w, lanes) \
    if ((lanes) == 0 || ((row_w) % (lanes)) != 0 || (row_w) < (lanes)) begin : g_bad_lanes \
        $error("row_serializer: ROW_W must be a non-zero multiple of LANES"); \
    end

package row_serializer_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Width of a bit index into a row; at least one bit.
    function automatic int unsigned idx_width(input int unsigned row_w);
        return (row_w > 1) ? $clog2(row_w) : 1;
    endfunction

    // Width able to hold a length of 0..row_w.
    function automatic int unsigned len_width(input int unsigned row_w);
        return $clog2(row_w + 1);
    endfunction

endpackage

`endif

// File: rtl/row_serializer_if.sv
// Row-in / beat-out bus of the row serializer.
// Signals:
//   in_valid, in_ready   row handshake
//   in_data  [ROW_W]     row payload, bit 0 emitted first
//   in_len   [LEN_W]     bits to emit from the row
//   out_valid, out_ready beat handshake
//   out_bits [LANES]     beat payload
//   out_index[IDX_W]     bit index of out_bits[0]
//   out_last             final beat of the row
// Modports: master drives rows and out_ready, slave is the serializer.
interface row_serializer_if #(
    parameter int unsigned ROW_W = 1280,
    parameter int unsigned LANES = 1
);
    import row_serializer_pkg::*;

    localparam int unsigned IDX_W = idx_width(ROW_W);
    localparam int unsigned LEN_W = len_width(ROW_W);

    logic             in_valid;
    logic             in_ready;
    logic [ROW_W-1:0] in_data;
    logic [LEN_W-1:0] in_len;
    logic             out_valid;
    logic             out_ready;
    logic [LANES-1:0] out_bits;
    logic [IDX_W-1:0] out_index;
    logic             out_last;

    modport master (
        output in_valid, in_data, in_len, out_ready,
        input  in_ready, out_valid, out_bits, out_index, out_last
    );

    modport slave (
        input  in_valid, in_data, in_len, out_ready,
        output in_ready, out_valid, out_bits, out_index, out_last
    );

endinterface

// File: rtl/row_shadow_buf.sv
// One-row holding buffer used to preload the next row while the current one
// is still being emitted (only instantiated with ROW_SERIALIZER_PRELOAD_EN).
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   load                 capture load_data/load_len and mark full
//   load_data, load_len  incoming row and its clamped length
//   take                 release the held row (load wins if both set)
//   full                 a row is held
//   data, len            held row and length
module row_shadow_buf #(
    parameter int unsigned ROW_W = 1280,
    parameter int unsigned LEN_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [ROW_W-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic             take,
    output logic             full,
    output logic [ROW_W-1:0] data,
    output logic [LEN_W-1:0] len
);

    // Payload capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= '0;
            len  <= '0;
        end else if (load) begin
            data <= load_data;
            len  <= load_len;
        end
    end

    // Occupancy: a same-cycle take and load leaves the slot full with the new row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (take) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/row_serializer.sv
// Row-to-stream serializer: accepts one RAM row per handshake and emits it as
// LANES-bit beats tagged with bit index and last flag, honouring a per-row
// emit length and downstream back-pressure.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   bus         row_serializer_if.slave (row input, beat output)
//   busy        a row is being emitted
// Build option: ROW_SERIALIZER_PRELOAD_EN adds a one-row shadow buffer so the
// next row can be accepted during emission and follow with no bubble.
module row_serializer
    import row_serializer_pkg::*;
#(
    parameter int unsigned ROW_W = 1280,
    parameter int unsigned LANES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    row_serializer_if.slave       bus,
    output logic                  busy
);

    localparam int unsigned IDX_W = idx_width(ROW_W);
    localparam int unsigned LEN_W = len_width(ROW_W);
    localparam int unsigned SUM_W = LEN_W + 1;

    `ROW_SERIALIZER_ASSERT_DIV(ROW_W, LANES)

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [LANES-1:0] out_bits_q, out_bits_d;
    logic             busy_q, busy_d;
    logic [LEN_W-1:0] in_len_clamped;
    logic             in_fire;
    logic             out_fire;

`ifdef ROW_SERIALIZER_PRELOAD_EN
    logic             shadow_load;
    logic             shadow_take;
    logic             shadow_full;
    logic             shadow_full_d;
    logic [ROW_W-1:0] shadow_data;
    logic [LEN_W-1:0] shadow_len;

    row_shadow_buf #(
        .ROW_W (ROW_W),
        .LEN_W (LEN_W)
    ) u_shadow (
        .clk       (clk),
        .reset     (reset),
        .load      (shadow_load),
        .load_data (bus.in_data),
        .load_len  (in_len_clamped),
        .take      (shadow_take),
        .full      (shadow_full),
        .data      (shadow_data),
        .len       (shadow_len)
    );
`endif

    assign in_len_clamped = (bus.in_len > LEN_W'(ROW_W)) ? LEN_W'(ROW_W) : bus.in_len;
    assign in_fire        = bus.in_valid && in_ready_q;
    assign out_fire       = out_valid_q && bus.out_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, active-row datapath and next registered outputs.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        len_d   = len_q;
        idx_d   = idx_q;
`ifdef ROW_SERIALIZER_PRELOAD_EN
        shadow_load = 1'b0;
        shadow_take = 1'b0;
`endif

        case (state_q)
            IDLE: begin
`ifdef ROW_SERIALIZER_PRELOAD_EN
                // A shadow row can be left over when an empty row was dropped
                // at the last beat while a new row landed in the freed slot.
                if (shadow_full) begin
                    shadow_take = 1'b1;
                    row_d       = shadow_data;
                    len_d       = shadow_len;
                    idx_d       = '0;
                    if (shadow_len != '0) begin
                        state_d = EMIT;
                    end
                end else
`endif
                if (in_fire) begin
                    row_d = bus.in_data;
                    len_d = in_len_clamped;
                    idx_d = '0;
                    if (in_len_clamped != '0) begin
                        state_d = EMIT;
                    end
                end
            end

            EMIT: begin
`ifdef ROW_SERIALIZER_PRELOAD_EN
                shadow_load = in_fire;
`endif
                if (out_fire) begin
                    if (!out_last_q) begin
                        // Shift the row so the next beat always sits in the low lanes.
                        row_d = row_q >> LANES;
                        idx_d = idx_q + IDX_W'(LANES);
                    end else begin
                        idx_d = '0;
`ifdef ROW_SERIALIZER_PRELOAD_EN
                        if (shadow_full) begin
                            shadow_take = 1'b1;
                            row_d       = shadow_data;
                            len_d       = shadow_len;
                            if (shadow_len == '0) begin
                                state_d = IDLE;
                            end
                        end else
`endif
                        begin
                            state_d = IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        out_valid_d = (state_d == EMIT);
        busy_d      = (state_d == EMIT);

        // Sum kept one bit wider than the length so it cannot wrap.
        out_last_d = (state_d == EMIT) &&
                     ((SUM_W'(idx_d) + SUM_W'(LANES)) >= SUM_W'(len_d));

        // Lanes at or beyond the row length read as zero.
        out_bits_d = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            if ((SUM_W'(idx_d) + SUM_W'(k)) < SUM_W'(len_d)) begin
                out_bits_d[k] = row_d[k];
            end
        end
        if (state_d != EMIT) begin
            out_bits_d = '0;
        end

`ifdef ROW_SERIALIZER_PRELOAD_EN
        shadow_full_d = shadow_take ? shadow_load : (shadow_full || shadow_load);
        in_ready_d    = !shadow_full_d;
`else
        in_ready_d    = (state_d == IDLE);
`endif
    end

    // Active row and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_bits_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            row_q       <= row_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_bits_q  <= out_bits_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bits  = out_bits_q;
    assign bus.out_index = idx_q;
    assign bus.out_last  = out_last_q;
    assign busy          = busy_q;

endmodule
